// File: rtl/iob_cpx_pkg.sv
// iob_cpx_pkg: shared constants and types for the IOB-to-CPX request controller.
//   NUM_DEST : number of CPX destination CPU ports
//   Q_DEPTH  : CPX input-queue slots per destination
//   CNT_W    : width of one outstanding-packet counter (holds 0..Q_DEPTH)
//   cnt_t    : one per-destination counter value
//   dest_t   : destination CPU index
//   beat_state_e : atomic second-beat FSM states
package iob_cpx_pkg;

    localparam int NUM_DEST = 8;
    localparam int Q_DEPTH  = 2;
    localparam int CNT_W    = $clog2(Q_DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [2:0]       dest_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } beat_state_e;

endpackage

// File: rtl/iob_cpx_credit_ctr.sv
// iob_cpx_credit_ctr: outstanding-packet counter for one CPX destination.
// Counts up by 0/1/2 on accepted packets and down by 1 on a grant,
// saturating at Q_DEPTH and holding at 0 on a grant with nothing outstanding.
//   rclk, reset : clock, asynchronous active-high reset
//   inc         : slots consumed this cycle (0, 1 or 2)
//   dec         : one slot freed this cycle (CPX grant)
//   cnt         : registered outstanding count
//   underflow   : combinational pulse, grant seen while count is 0
module iob_cpx_credit_ctr #(
    parameter int Q_DEPTH = 2,
    parameter int CW      = $clog2(Q_DEPTH + 1)
) (
    input  logic          rclk,
    input  logic          reset,
    input  logic [1:0]    inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          underflow
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [CW:0]   sum_s;

    // Next count: add the increment, subtract a grant only when something is outstanding.
    always_comb begin
        sum_s     = {1'b0, cnt_r} + (CW+1)'(inc);
        underflow = dec && (cnt_r == {CW{1'b0}});
        if (dec && (cnt_r != {CW{1'b0}})) begin
            sum_s = sum_s - {{CW{1'b0}}, 1'b1};
        end else begin
            sum_s = sum_s;
        end
        if (sum_s > (CW+1)'(Q_DEPTH)) begin
            cnt_nxt_s = CW'(Q_DEPTH);
        end else begin
            cnt_nxt_s = sum_s[CW-1:0];
        end
    end

    // Count register.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/iob_cpx_req_ctl.sv
// iob_cpx_req_ctl: credit-based request controller issuing IOB packets to CPX.
// Stalls the source whenever a packet would overflow the destination's CPX
// queue; atomics take two slots and issue a second request beat.
//   rclk, reset       : clock, asynchronous active-high reset
//   src_vld/src_rdy   : source handshake, accept when both high
//   src_dest          : destination CPU index
//   src_atom          : two-beat atomic packet
//   cpx_io_grant_cx2  : flopped CPX grant, one freed slot per set bit
//   io_cpx_req_cq     : registered one-hot request pulse
//   cred_cnt          : packed outstanding counts, destination 0 in the LSBs
//   err_underflow     : sticky, grant arrived for a destination with count 0
module iob_cpx_req_ctl
    import iob_cpx_pkg::*;
#(
    parameter int NUM_DEST = iob_cpx_pkg::NUM_DEST,
    parameter int Q_DEPTH  = iob_cpx_pkg::Q_DEPTH
) (
    input  logic                    rclk,
    input  logic                    reset,
    input  logic                    src_vld,
    input  logic [2:0]              src_dest,
    input  logic                    src_atom,
    output logic                    src_rdy,
    input  logic [NUM_DEST-1:0]     cpx_io_grant_cx2,
    output logic [NUM_DEST-1:0]     io_cpx_req_cq,
    output logic [NUM_DEST*$clog2(Q_DEPTH+1)-1:0] cred_cnt,
    output logic                    err_underflow
);

    localparam int CW = $clog2(Q_DEPTH + 1);

    logic [CW-1:0]       cnt_s [NUM_DEST];
    logic [1:0]          inc_s [NUM_DEST];
    logic [NUM_DEST-1:0] uflow_s;
    logic [CW-1:0]       cnt_sel_s;
    logic [CW+1:0]       total_s;
    logic [1:0]          need_s;
    logic                dest_ok_s;
    logic                accept_s;
    logic                beat2_pend_s;
    beat_state_e         state_r;
    beat_state_e         state_nxt_s;
    dest_t               beat2_dest_r;
    logic [NUM_DEST-1:0] req_r;
    logic [NUM_DEST-1:0] req_nxt_s;
    logic                err_r;

    assign need_s       = src_atom ? 2'd2 : 2'd1;
    assign dest_ok_s    = int'(src_dest) < NUM_DEST;
    assign beat2_pend_s = (state_r == ST_BEAT2);

    // Select the count for src_dest; a loop keeps out-of-range indices harmless.
    always_comb begin
        cnt_sel_s = {CW{1'b0}};
        for (int d = 0; d < NUM_DEST; d++) begin
            if (int'(src_dest) == d) begin
                cnt_sel_s = cnt_s[d];
            end else begin
                cnt_sel_s = cnt_sel_s;
            end
        end
    end

    // Requests are counted in the same edge that registers them, so nothing
    // registered-but-uncounted exists and only the current count matters.
    // The same-cycle grant is deliberately not bypassed into this check.
    assign total_s  = (CW+2)'(cnt_sel_s) + (CW+2)'(need_s);
    assign src_rdy  = !beat2_pend_s && dest_ok_s && (total_s <= (CW+2)'(Q_DEPTH));
    assign accept_s = src_vld && src_rdy;

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
        assign inc_s[g] = (accept_s && (int'(src_dest) == g)) ? need_s : 2'b00;

        iob_cpx_credit_ctr #(
            .Q_DEPTH (Q_DEPTH),
            .CW      (CW)
        ) u_ctr (
            .rclk      (rclk),
            .reset     (reset),
            .inc       (inc_s[g]),
            .dec       (cpx_io_grant_cx2[g]),
            .cnt       (cnt_s[g]),
            .underflow (uflow_s[g])
        );

        assign cred_cnt[g*CW +: CW] = cnt_s[g];
    end

    // Atomic second-beat FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && src_atom) begin
                    state_nxt_s = ST_BEAT2;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BEAT2: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Next request vector: new accept, else the pending second beat, else idle.
    always_comb begin
        req_nxt_s = {NUM_DEST{1'b0}};
        for (int d = 0; d < NUM_DEST; d++) begin
            if (accept_s && (int'(src_dest) == d)) begin
                req_nxt_s[d] = 1'b1;
            end else if (beat2_pend_s && (int'(beat2_dest_r) == d)) begin
                req_nxt_s[d] = 1'b1;
            end else begin
                req_nxt_s[d] = 1'b0;
            end
        end
    end

    // FSM state and latched second-beat destination.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            beat2_dest_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s && src_atom) begin
                beat2_dest_r <= src_dest;
            end else begin
                beat2_dest_r <= beat2_dest_r;
            end
        end
    end

    // Request pulse register and sticky underflow flag.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            req_r <= {NUM_DEST{1'b0}};
            err_r <= 1'b0;
        end else begin
            req_r <= req_nxt_s;
            err_r <= err_r | (|uflow_s);
        end
    end

    assign io_cpx_req_cq = req_r;
    assign err_underflow = err_r;

endmodule

// File: tb/tb_iob_cpx_req_ctl.sv
// tb_iob_cpx_req_ctl: directed, table-driven bench for iob_cpx_req_ctl.
// Inputs change on the falling edge; outputs are compared 1 ns later, so
// registered outputs reflect all vectors applied before the preceding rising edge.
module tb_iob_cpx_req_ctl;

    logic        rclk;
    logic        reset;
    logic        src_vld;
    logic [2:0]  src_dest;
    logic        src_atom;
    logic        src_rdy;
    logic [7:0]  cpx_io_grant_cx2;
    logic [7:0]  io_cpx_req_cq;
    logic [15:0] cred_cnt;
    logic        err_underflow;

    int checks;
    int errors;

    typedef struct {
        logic        vld;
        logic [2:0]  dest;
        logic        atom;
        logic [7:0]  grant;
        logic        rdy;
        logic [7:0]  req;
        logic [15:0] cred;
        logic        err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    iob_cpx_req_ctl dut (
        .rclk             (rclk),
        .reset            (reset),
        .src_vld          (src_vld),
        .src_dest         (src_dest),
        .src_atom         (src_atom),
        .src_rdy          (src_rdy),
        .cpx_io_grant_cx2 (cpx_io_grant_cx2),
        .io_cpx_req_cq    (io_cpx_req_cq),
        .cred_cnt         (cred_cnt),
        .err_underflow    (err_underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] d, input logic a, input logic [7:0] g);
        src_vld          = v;
        src_dest         = d;
        src_atom         = a;
        cpx_io_grant_cx2 = g;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //          vld   dest  atom  grant  | rdy  req    cred_cnt  err
        // three singles to dest 3, stall, grant frees a slot
        vecs[0]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 8'h00, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 8'h08, 16'h0040, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 8'h08, 16'h0080, 1'b0};
        vecs[4]  = '{1'b1, 3'd3, 1'b0, 8'h08, 1'b0, 8'h00, 16'h0080, 1'b0};
        vecs[5]  = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 8'h00, 16'h0040, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h08, 16'h0080, 1'b0};
        // atomic to dest 5, rejected retries, two grants, second atomic
        vecs[7]  = '{1'b1, 3'd5, 1'b1, 8'h00, 1'b1, 8'h00, 16'h0080, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h20, 16'h0880, 1'b0};
        vecs[9]  = '{1'b1, 3'd5, 1'b1, 8'h00, 1'b0, 8'h20, 16'h0880, 1'b0};
        vecs[10] = '{1'b1, 3'd5, 1'b1, 8'h20, 1'b0, 8'h00, 16'h0880, 1'b0};
        vecs[11] = '{1'b1, 3'd5, 1'b1, 8'h20, 1'b0, 8'h00, 16'h0480, 1'b0};
        vecs[12] = '{1'b1, 3'd5, 1'b1, 8'h00, 1'b1, 8'h00, 16'h0080, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b0, 8'h20, 16'h0880, 1'b0};
        vecs[14] = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 8'h20, 16'h0480, 1'b0};
        // same-cycle accept and grant on dest 0
        vecs[15] = '{1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h0080, 1'b0};
        vecs[16] = '{1'b1, 3'd0, 1'b0, 8'h01, 1'b1, 8'h01, 16'h0081, 1'b0};
        vecs[17] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h01, 16'h0081, 1'b0};
        // underflow on dest 7, then a multi-destination grant
        vecs[18] = '{1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 8'h00, 16'h0081, 1'b0};
        vecs[19] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h0081, 1'b1};
        vecs[20] = '{1'b0, 3'd0, 1'b0, 8'h09, 1'b1, 8'h00, 16'h0081, 1'b1};
        vecs[21] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h0040, 1'b1};

        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 8'h00);
        repeat (2) @(negedge rclk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].vld, vecs[i].dest, vecs[i].atom, vecs[i].grant);
            #1;
            chk($sformatf("v%0d_rdy", i),  32'(src_rdy),       32'(vecs[i].rdy));
            chk($sformatf("v%0d_req", i),  32'(io_cpx_req_cq), 32'(vecs[i].req));
            chk($sformatf("v%0d_cred", i), 32'(cred_cnt),      32'(vecs[i].cred));
            chk($sformatf("v%0d_err", i),  32'(err_underflow), 32'(vecs[i].err));
            @(negedge rclk);
        end

        // Reset asserted in the cycle after an atomic accept to dest 2.
        drive(1'b1, 3'd2, 1'b1, 8'h00);
        #1;
        chk("rst_atom_rdy", 32'(src_rdy), 32'd1);
        @(negedge rclk);
        drive(1'b0, 3'd0, 1'b0, 8'h00);
        #1;
        chk("rst_pre_req", 32'(io_cpx_req_cq), 32'h04);
        reset = 1'b1;
        #1;
        chk("rst_req",  32'(io_cpx_req_cq), 32'h00);
        chk("rst_cred", 32'(cred_cnt),      32'h0000);
        chk("rst_err",  32'(err_underflow), 32'd0);
        chk("rst_rdy",  32'(src_rdy),       32'd1);
        @(negedge rclk);
        reset = 1'b0;
        drive(1'b1, 3'd2, 1'b1, 8'h00);
        #1;
        chk("post_rst_req", 32'(io_cpx_req_cq), 32'h00);
        chk("post_rst_rdy", 32'(src_rdy),       32'd1);
        @(negedge rclk);
        drive(1'b0, 3'd0, 1'b0, 8'h00);
        #1;
        chk("post_rst_req2",  32'(io_cpx_req_cq), 32'h04);
        chk("post_rst_cred2", 32'(cred_cnt),      32'h0020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
